usb_rx_packet_buffer: RTL and testbench
=======================================

USB_RX_PACKET_BUFFER -- requirements
Module: usb_rx_packet_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: n_rst  in  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-003 SHALL have ports: rx_r_data  in  8  receiver FIFO head byte, valid whenever rx_empty=0.
REQ-004 SHALL have ports: rx_empty  in  1  receiver FIFO empty; rx_rcving  in  1  packet in progress; rx_error  in  1  receiver error; rx_pid  in  4  decoded PID.
REQ-005 SHALL have ports: rx_r_enable  out  1  pops one byte from the receiver FIFO on the same rising edge.
REQ-006 SHALL have ports: buf_rd_en  in  1  host read strobe; buf_rd_data  out  8  byte at read pointer; pkt_ack  in  1  host releases buffer.
REQ-007 SHALL have ports: pkt_ready  out  1; pkt_pid  out  4; pkt_len  out  7 (0-64); pkt_error  out  1; pkt_overflow  out  1; err_count  out  8.

Function
REQ-008 SHALL store up to 64 bytes in an internal 64x8 array with a write pointer wr_ptr (7 bits) and a read pointer rd_ptr (6 bits).
REQ-009 SHALL implement FSM states: IDLE, COLLECT, READY.
REQ-010 SHALL have the following IDLE behaviour: rx_r_enable=0; transition to COLLECT on rx_rcving=1 or rx_empty=0; wr_ptr, rd_ptr, error and overflow flags cleared on entry.
REQ-011 SHALL assert rx_r_enable in COLLECT combinationally iff rx_empty=0; each pop stores rx_r_data at mem[wr_ptr] and increments wr_ptr on the same edge.
REQ-012 SHALL handle overflow as follows: when a pop occurs with wr_ptr=64, discard the byte, set pkt_overflow and keep popping until the packet ends; wr_ptr saturates at 64.
REQ-013 SHALL set a sticky error flag if rx_error=1 on any COLLECT cycle.
REQ-014 SHALL end the packet when COLLECT sees rx_rcving=0 and rx_empty=1: next state READY; pkt_pid<=rx_pid; pkt_len<=wr_ptr; pkt_error<=error flag OR overflow flag, all on the same edge.
REQ-015 SHALL have the following READY behaviour: pkt_ready=1; rx_r_enable=0 (new receiver traffic backs up in the receiver FIFO); pkt_pid/pkt_len/pkt_error/pkt_overflow held stable.
REQ-016 SHALL drive buf_rd_data=mem[rd_ptr] combinationally while in READY and rd_ptr<pkt_len, and 8'h00 otherwise.
REQ-017 SHALL increment rd_ptr by 1 on buf_rd_en=1 in READY with rd_ptr<pkt_len; reads past pkt_len are ignored.
REQ-018 SHALL return the FSM from READY to IDLE on pkt_ack=1, with pkt_ready=0 from the next cycle; if buf_rd_en and pkt_ack are both 1, pkt_ack wins and rd_ptr clears.
REQ-019 SHALL ignore pkt_ack and buf_rd_en outside READY.
REQ-020 SHALL accept a zero-length packet (rx_rcving pulse, no bytes): READY with pkt_len=0.
REQ-021 SHALL NOT require rx_rcving to fall before draining; bytes are popped as soon as they are available.

Reset
REQ-022 SHALL, while n_rst=1, force asynchronously: state=IDLE, wr_ptr=0, rd_ptr=0, pkt_ready=0, pkt_pid=4'h0, pkt_len=0, pkt_error=0, pkt_overflow=0, err_count=0, rx_r_enable=0, buf_rd_data=8'h00.
REQ-023 SHALL discard a partially collected packet on reset mid-COLLECT; array contents need not be cleared.

Configuration
REQ-024 SHALL, when USB_RXBUF_ERR_CNT_EN is defined, implement err_count as an 8-bit counter that increments on each COLLECT->READY transition with pkt_error=1 and saturates at 8'hFF.
REQ-025 SHALL, when USB_RXBUF_ERR_CNT_EN is undefined, tie err_count to 8'h00 and omit all counter logic.

Verification
REQ-026 SHALL verify: rx_rcving pulse with 3 bytes A5,3C,F0 and PID 4'h3 -> pkt_ready=1, pkt_len=3, pkt_pid=3, pkt_error=0; 3 buf_rd_en give A5,3C,F0; pkt_ack -> pkt_ready=0 next cycle.
REQ-027 SHALL verify: a 70-byte packet -> pkt_len=64, pkt_overflow=1, pkt_error=1, rx_empty=1 at READY (all 70 bytes popped).
REQ-028 SHALL verify: rx_error pulsed mid-packet on a 5-byte packet -> pkt_error=1, pkt_len=5; with USB_RXBUF_ERR_CNT_EN, err_count=1.
REQ-029 SHALL verify: a second packet arrives during READY -> rx_r_enable=0 until pkt_ack; after ack, the second packet is collected intact.
REQ-030 SHALL verify: n_rst asserted after 10 bytes of COLLECT -> all outputs at reset values immediately; the next packet reports its own pkt_len.
REQ-031 SHALL verify: zero-length packet -> pkt_len=0; buf_rd_en yields buf_rd_data=00 and rd_ptr stays 0.

Source files
------------

// File: rtl/usb_rx_packet_buffer.sv
// usb_rx_packet_buffer: collects one USB receive packet (up to 64 bytes) from the receiver FIFO and holds it for the host.
// Define USB_RXBUF_ERR_CNT_EN to build the saturating err_count packet-error counter; otherwise err_count is tied to 0.
module usb_rx_packet_buffer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] rx_r_data,
    input  logic       rx_empty,
    input  logic       rx_rcving,
    input  logic       rx_error,
    input  logic [3:0] rx_pid,
    output logic       rx_r_enable,
    input  logic       buf_rd_en,
    output logic [7:0] buf_rd_data,
    input  logic       pkt_ack,
    output logic       pkt_ready,
    output logic [3:0] pkt_pid,
    output logic [6:0] pkt_len,
    output logic       pkt_error,
    output logic       pkt_overflow,
    output logic [7:0] err_count
);
    typedef enum logic [1:0] {IDLE, COLLECT, READY} state_t;
    state_t     state, state_next;
    logic [7:0] mem [64];
    logic [6:0] wr_ptr;
    logic [5:0] rd_ptr;
    logic       rd_all;
    logic       err_flag;
    logic       pkt_end;
    logic       pkt_err_next;
    logic       rd_ok;
    // Next state, receiver pop strobe and end-of-packet detect.
    always_comb begin
        state_next  = state;
        rx_r_enable = 1'b0;
        pkt_end     = 1'b0;
        case (state)
            IDLE:    state_next = (rx_rcving || !rx_empty) ? COLLECT : IDLE;
            COLLECT: begin
                rx_r_enable = !rx_empty;
                pkt_end     = !rx_rcving && rx_empty;
                state_next  = pkt_end ? READY : COLLECT;
            end
            READY:   state_next = pkt_ack ? IDLE : READY;
            default: state_next = IDLE;
        endcase
    end
    // rd_all marks that all 64 entries were read, since the 6-bit rd_ptr wraps back to 0.
    assign pkt_ready    = (state == READY);
    assign rd_ok        = pkt_ready && !rd_all && ({1'b0, rd_ptr} < pkt_len);
    assign buf_rd_data  = rd_ok ? mem[rd_ptr] : 8'h00;
    assign pkt_err_next = err_flag || rx_error || pkt_overflow;
    // State register, pointers, sticky flags and the latched packet descriptor.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_all       <= 1'b0;
            err_flag     <= 1'b0;
            pkt_overflow <= 1'b0;
            pkt_pid      <= '0;
            pkt_len      <= '0;
            pkt_error    <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == IDLE) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                rd_all       <= 1'b0;
                err_flag     <= 1'b0;
                pkt_overflow <= 1'b0;
            end else if (state == COLLECT) begin
                if (rx_error)
                    err_flag <= 1'b1;
                if (rx_r_enable) begin
                    if (wr_ptr[6])
                        pkt_overflow <= 1'b1;
                    else
                        wr_ptr <= wr_ptr + 7'd1;
                end
                if (pkt_end) begin
                    pkt_pid   <= rx_pid;
                    pkt_len   <= wr_ptr;
                    pkt_error <= pkt_err_next;
                end
            end else if (buf_rd_en && rd_ok) begin
                rd_ptr <= rd_ptr + 6'd1;
                if (&rd_ptr)
                    rd_all <= 1'b1;
            end
        end
    end
    // Packet storage; bytes popped after the buffer is full are dropped.
    always_ff @(posedge clk) begin
        if (rx_r_enable && !wr_ptr[6])
            mem[wr_ptr[5:0]] <= rx_r_data;
    end
`ifdef USB_RXBUF_ERR_CNT_EN
    // Saturating count of packets completed with an error.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst)
            err_count <= '0;
        else if (pkt_end && pkt_err_next && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'h00;
`endif
endmodule

// File: tb/tb_usb_rx_packet_buffer.sv
// tb_usb_rx_packet_buffer: table-driven and sequence checks of usb_rx_packet_buffer with a byte scoreboard.
module tb_usb_rx_packet_buffer;
    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic [7:0] rx_r_data;
    logic       rx_empty;
    logic       rx_rcving = 1'b0;
    logic       rx_error = 1'b0;
    logic [3:0] rx_pid = 4'h0;
    logic       rx_r_enable;
    logic       buf_rd_en = 1'b0;
    logic [7:0] buf_rd_data;
    logic       pkt_ack = 1'b0;
    logic       pkt_ready;
    logic [3:0] pkt_pid;
    logic [6:0] pkt_len;
    logic       pkt_error;
    logic       pkt_overflow;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    usb_rx_packet_buffer dut (
        .clk(clk), .n_rst(n_rst), .rx_r_data(rx_r_data), .rx_empty(rx_empty),
        .rx_rcving(rx_rcving), .rx_error(rx_error), .rx_pid(rx_pid), .rx_r_enable(rx_r_enable),
        .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data), .pkt_ack(pkt_ack), .pkt_ready(pkt_ready),
        .pkt_pid(pkt_pid), .pkt_len(pkt_len), .pkt_error(pkt_error), .pkt_overflow(pkt_overflow),
        .err_count(err_count)
    );

    // Receiver FIFO model: the bench appends at fifo_wr, the DUT pops via rx_r_enable.
    logic [7:0]  fifo_mem [2048];
    logic [10:0] fifo_wr = '0;
    logic [10:0] pop_cnt = '0;
    assign rx_empty  = (fifo_wr == pop_cnt);
    assign rx_r_data = fifo_mem[pop_cnt];
    always @(posedge clk) if (rx_r_enable) pop_cnt <= pop_cnt + 11'd1;

    logic [7:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    typedef struct {
        int         n;
        logic [3:0] pid;
        int         err_at;
        int         len;
        logic       err;
        logic       ovf;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit sb);
        fifo_mem[fifo_wr] = b;
        fifo_wr = fifo_wr + 11'd1;
        if (sb) exp_q.push_back(b);
    endtask

    task automatic finish_pkt(input int err_at);
        @(negedge clk);
        for (int c = 1; c < 200 && !rx_empty; c++) begin
            rx_error = (c == err_at);
            @(negedge clk);
        end
        rx_error = 1'b0;
        chk("fifo_drained", 32'(rx_empty), 32'd1);
        rx_rcving = 1'b0;
        for (int c = 0; c < 8 && !pkt_ready; c++) @(negedge clk);
        chk("pkt_ready_up", 32'(pkt_ready), 32'd1);
    endtask

    task automatic check_pkt(input int len, input logic [3:0] pid, input logic err, input logic ovf);
        chk("pkt_len", 32'(pkt_len), 32'(len));
        chk("pkt_pid", 32'(pkt_pid), 32'(pid));
        chk("pkt_error", 32'(pkt_error), 32'(err));
        chk("pkt_overflow", 32'(pkt_overflow), 32'(ovf));
        chk("ready_no_pop", 32'(rx_r_enable), 32'd0);
        if (err && exp_cnt < 255) exp_cnt++;
`ifdef USB_RXBUF_ERR_CNT_EN
        chk("err_count", 32'(err_count), 32'(exp_cnt));
`else
        chk("err_count", 32'(err_count), 32'd0);
`endif
    endtask

    task automatic drain_ack(input int len);
        logic [7:0] e;
        for (int i = 0; i < len; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("rd_data[%0d]", i), 32'(buf_rd_data), 32'(e));
            buf_rd_en = 1'b1;
            @(negedge clk);
        end
        buf_rd_en = 1'b1;
        @(negedge clk);
        chk("rd_past_end", 32'(buf_rd_data), 32'd0);
        chk("ready_hold", 32'(pkt_ready), 32'd1);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        buf_rd_en = 1'b0;
        chk("ack_ready_low", 32'(pkt_ready), 32'd0);
        chk("ack_ovf_clear", 32'(pkt_overflow), 32'd0);
        chk("ack_rd_data", 32'(buf_rd_data), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(pkt_ready), 32'd0);
        chk({tag, "_pid"}, 32'(pkt_pid), 32'd0);
        chk({tag, "_len"}, 32'(pkt_len), 32'd0);
        chk({tag, "_err"}, 32'(pkt_error), 32'd0);
        chk({tag, "_ovf"}, 32'(pkt_overflow), 32'd0);
        chk({tag, "_cnt"}, 32'(err_count), 32'd0);
        chk({tag, "_ren"}, 32'(rx_r_enable), 32'd0);
        chk({tag, "_rdata"}, 32'(buf_rd_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            n   pid    err_at len err   ovf
        vecs[0] = '{  1, 4'h9,  -1,    1, 1'b0, 1'b0};
        vecs[1] = '{  5, 4'hB,   2,    5, 1'b1, 1'b0};
        vecs[2] = '{ 64, 4'h1,  -1,   64, 1'b0, 1'b0};
        vecs[3] = '{ 65, 4'h2,  -1,   64, 1'b1, 1'b1};
        vecs[4] = '{ 70, 4'hD,  -1,   64, 1'b1, 1'b1};
        vecs[5] = '{  0, 4'h5,  -1,    0, 1'b0, 1'b0};
        vecs[6] = '{ 17, 4'hF,   1,   17, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check_reset_outputs("init_rst");
        n_rst = 1'b0;
        @(negedge clk);

        rx_pid = 4'h3;
        rx_rcving = 1'b1;
        push_byte(8'hA5, 1'b1);
        push_byte(8'h3C, 1'b1);
        push_byte(8'hF0, 1'b1);
        finish_pkt(-1);
        check_pkt(3, 4'h3, 1'b0, 1'b0);
        drain_ack(3);

        for (int v = 0; v < 7; v++) begin
            rx_pid = vecs[v].pid;
            rx_rcving = 1'b1;
            for (int i = 0; i < vecs[v].n; i++) push_byte(8'($urandom_range(0, 255)), i < 64);
            finish_pkt(vecs[v].err_at);
            check_pkt(vecs[v].len, vecs[v].pid, vecs[v].err, vecs[v].ovf);
            drain_ack(vecs[v].len);
        end

        rx_pid = 4'h6;
        rx_rcving = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
        finish_pkt(-1);
        check_pkt(4, 4'h6, 1'b0, 1'b0);
        rx_pid = 4'h7;
        rx_rcving = 1'b1;
        for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_no_pop", 32'(rx_r_enable), 32'd0);
            chk("busy_pid_hold", 32'(pkt_pid), 32'h6);
        end
        chk("busy_fifo_level", 32'(fifo_wr - pop_cnt), 32'd6);
        drain_ack(4);
        finish_pkt(-1);
        check_pkt(6, 4'h7, 1'b0, 1'b0);
        drain_ack(6);

        rx_pid = 4'hA;
        rx_rcving = 1'b1;
        for (int i = 0; i < 10; i++) push_byte(8'($urandom_range(0, 255)), 1'b0);
        @(negedge clk);
        for (int c = 0; c < 50 && !rx_empty; c++) @(negedge clk);
        push_byte(8'h5A, 1'b0);
        #1;
        chk("pre_rst_pop", 32'(rx_r_enable), 32'd1);
        n_rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        exp_cnt = 0;
        @(negedge clk);
        fifo_wr = pop_cnt;
        rx_rcving = 1'b0;
        n_rst = 1'b0;
        @(negedge clk);
        rx_pid = 4'hC;
        rx_rcving = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
        finish_pkt(-1);
        check_pkt(4, 4'hC, 1'b0, 1'b0);
        drain_ack(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
